// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count_sched interval scheduler.
package count_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 33;

    localparam logic [CW_DEF-1:0] CW_ZERO = '0;
    localparam logic [CW_DEF-1:0] CW_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/count_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          valid
);

    int p;

    always_comb begin
        win     = '0;
        win_idx = '0;
        valid   = 1'b0;
        p       = 0;
        for (int k = 0; k < N; k++) begin
            p = (int'(rr) + k) % N;
            if (!valid && req[p[IW-1:0]]) begin
                valid             = 1'b1;
                win[p[IW-1:0]]    = 1'b1;
                win_idx           = p[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/count_sched.sv
// Grants a shared interval counter to one requester at a time and sequences
// clear / count / compare until the requested interval has elapsed.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] dur,
    input  logic [NREQ-1:0]    abort,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               cnt_clear,
    output logic               cnt_en,
    output logic [CW-1:0]      cnt_cmp,
    input  logic               cnt_match,
    input  logic               cnt_wrap,
    output logic               busy,
    output logic               err
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [RW-1:0]   rr;
    logic [RW-1:0]   rr_nxt;
    logic [NREQ-1:0] win;
    logic [RW-1:0]   win_idx;
    logic            win_vld;
    logic [CW-1:0]   dur_win;
    logic            zero_q;
    logic            run_en;
    logic            g_cancel;

    rr_arbiter #(.N(NREQ), .IW(RW)) u_arb (
        .req     (req),
        .rr      (rr),
        .win     (win),
        .win_idx (win_idx),
        .valid   (win_vld)
    );

    always_comb begin
        dur_win = '0;
        for (int i = 0; i < NREQ; i++)
            if (win[i]) dur_win = dur[i*CW +: CW];
    end

    assign rr_nxt   = (win_idx == RW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    assign g_cancel = (|(abort & grant)) | ~(|(req & grant));

    // Enable drops in the very cycle the counter reports a match, so it never overshoots.
    assign cnt_en = run_en & ~cnt_match;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rr        <= '0;
            grant     <= '0;
            done      <= '0;
            cnt_cmp   <= CW'(CW_ZERO);
            zero_q    <= 1'b0;
            run_en    <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            cnt_clear <= 1'b1;
        end else begin
            done      <= '0;
            cnt_clear <= 1'b0;
            unique case (state)
                S_IDLE: if (win_vld) begin
                    grant     <= win;
                    cnt_cmp   <= dur_win;
                    zero_q    <= (dur_win == CW'(CW_ZERO));
                    rr        <= rr_nxt;
                    cnt_clear <= 1'b1;
                    busy      <= 1'b1;
                    state     <= S_LOAD;
                end
                // A zero-length interval spends one RUN cycle with the enable held
                // off, so done lands at grant+2 like the general N+2 rule.
                S_LOAD: if (g_cancel) begin
                    grant     <= '0;
                    cnt_clear <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end else begin
                    run_en    <= ~zero_q;
                    state     <= S_RUN;
                end
                S_RUN: if (cnt_match || zero_q) begin
                    done      <= grant;
                    run_en    <= 1'b0;
                    state     <= S_DONE;
                end else if (cnt_wrap) begin
                    err       <= 1'b1;
                    done      <= grant;
                    run_en    <= 1'b0;
                    state     <= S_DONE;
                end else if (g_cancel) begin
                    grant     <= '0;
                    run_en    <= 1'b0;
                    cnt_clear <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                S_DONE: begin
                    grant     <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_sched.sv
// Directed and randomized checks of count_sched against a behavioural model
// of the external counter and the round-robin/latency rules.
module tb_count_sched;
    import count_sched_pkg::*;

    localparam int NREQ = NREQ_DEF;
    localparam int CW   = CW_DEF;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] dur;
    logic [NREQ-1:0]    abort;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               cnt_clear;
    logic               cnt_en;
    logic [CW-1:0]      cnt_cmp;
    logic               cnt_match;
    logic               cnt_wrap;
    logic               busy;
    logic               err;

    logic [CW-1:0] cnt = '0;
    logic          force_wrap;
    int            n_chk = 0;
    int            n_fail = 0;
    int            rr_m = 0;

    count_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .dur       (dur),
        .abort     (abort),
        .grant     (grant),
        .done      (done),
        .cnt_clear (cnt_clear),
        .cnt_en    (cnt_en),
        .cnt_cmp   (cnt_cmp),
        .cnt_match (cnt_match),
        .cnt_wrap  (cnt_wrap),
        .busy      (busy),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Shared counter the scheduler drives.
    always @(posedge clock) begin
        if (cnt_clear)   cnt <= '0;
        else if (cnt_en) cnt <= cnt + 1'b1;
    end
    assign cnt_match = (cnt == cnt_cmp);
    assign cnt_wrap  = force_wrap | (cnt == CW_ONES);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int from);
        for (int k = 0; k < NREQ; k++)
            if (m[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    // One full grant..done transaction for requester w with interval n.
    task automatic serve(input int w, input int n, input bit drop, input bit scramble);
        int              cyc, en_cyc, clr_cyc;
        bit              stable;
        logic [NREQ-1:0] g0;
        g0   = NREQ'(1) << w;
        rr_m = (w + 1) % NREQ;
        tick();
        chk("grant", grant, g0);
        chk("busy", busy, 1);
        chk("cmp", cnt_cmp, n);
        if (scramble)
            for (int i = 0; i < NREQ; i++) dur[i*CW +: CW] = CW'($urandom_range(0, 7));
        cyc = 0; en_cyc = 0; clr_cyc = 0; stable = 1'b1;
        while (done == '0 && cyc < n + 8) begin
            en_cyc  += int'(cnt_en);
            clr_cyc += int'(cnt_clear);
            if (grant !== g0) stable = 1'b0;
            tick();
            cyc++;
        end
        chk("done", done, g0);
        chk("latency", cyc, n + 2);
        chk("en_cycles", en_cyc, n);
        chk("clear_cycles", clr_cyc, 1);
        chk("grant_stable", stable && (grant === g0), 1);
        if (drop) req[w] = 1'b0;
        tick();
        chk("idle_grant", grant, 0);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        logic [NREQ-1:0] mask;
        int              w, n;

        reset_n = 1'b0; req = '0; abort = '0; dur = '0; force_wrap = 1'b0;
        tick(); tick();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_clear", cnt_clear, 1);
        chk("rst_en", cnt_en, 0);
        chk("rst_cmp", cnt_cmp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;

        // single requester, dur 5
        req[0] = 1'b1; dur[0*CW +: CW] = 5;
        serve(0, 5, 1, 0);
        // zero-length interval
        req[2] = 1'b1; dur[2*CW +: CW] = 0;
        serve(2, 0, 1, 0);
        req[3] = 1'b1; dur[3*CW +: CW] = 1;
        serve(3, 1, 1, 0);

        // all requesting, held through done: strict rotation
        for (int i = 0; i < NREQ; i++) dur[i*CW +: CW] = 1;
        req = '1;
        serve(0, 1, 0, 0);
        serve(1, 1, 0, 0);
        serve(2, 1, 0, 0);
        serve(3, 1, 0, 0);
        serve(0, 1, 0, 0);
        req = '0;

        // abort of grantee 1 at count 3; non-grantee abort ignored
        dur[1*CW +: CW] = 10; dur[2*CW +: CW] = 2;
        req = 4'b0110;
        tick();
        chk("abort_grant", grant, 4'b0010);
        rr_m = 2;
        abort[3] = 1'b1;
        for (int i = 0; i < 30 && cnt != 3; i++) tick();
        chk("abort_still_granted", grant, 4'b0010);
        chk("abort_at_3", cnt, 3);
        abort[1] = 1'b1;
        tick();
        chk("abort_cleared", grant, 0);
        chk("abort_no_done", done, 0);
        chk("abort_clear", cnt_clear, 1);
        chk("abort_busy", busy, 0);
        abort = '0; req[1] = 1'b0;
        serve(2, 2, 1, 0);

        // counter wraps before match
        dur[3*CW +: CW] = 20; req[3] = 1'b1;
        tick();
        chk("wrap_grant", grant, 4'b1000);
        rr_m = 0;
        for (int i = 0; i < 30 && cnt != 3; i++) tick();
        force_wrap = 1'b1;
        tick();
        force_wrap = 1'b0;
        chk("wrap_done", done, 4'b1000);
        chk("wrap_err", err, 1);
        req = '0;
        tick();
        chk("wrap_idle", grant, 0);
        chk("err_sticky", err, 1);
        req[0] = 1'b1; dur[0*CW +: CW] = 1;
        serve(0, 1, 1, 0);
        chk("err_sticky2", err, 1);

        // randomized rounds checked against the round-robin / N+2 model
        for (int r = 0; r < 25; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) dur[i*CW +: CW] = CW'($urandom_range(0, 9));
            req = mask;
            while (mask != '0) begin
                w = pick(mask, rr_m);
                n = int'(dur[w*CW +: CW]);
                serve(w, n, 1, r[0]);
                mask[w] = 1'b0;
            end
        end

        // reset in the middle of RUN
        for (int i = 0; i < NREQ; i++) dur[i*CW +: CW] = 10;
        req = 4'b0010;
        tick(); tick(); tick(); tick();
        reset_n = 1'b0; req = '0;
        tick();
        chk("mid_grant", grant, 0);
        chk("mid_done", done, 0);
        chk("mid_clear", cnt_clear, 1);
        chk("mid_en", cnt_en, 0);
        chk("mid_cmp", cnt_cmp, 0);
        chk("mid_busy", busy, 0);
        chk("mid_err", err, 0);
        reset_n = 1'b1;
        tick();
        chk("mid_no_done", done, 0);
        rr_m = 0;
        for (int i = 0; i < NREQ; i++) dur[i*CW +: CW] = 1;
        req = '1;
        serve(0, 1, 1, 0);
        req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
